// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bundle bit positions, instruction
// field positions and a small immediate helper used by the decode side.
package pipe_pkg;

    localparam int CTRL_W = 10;

    // Control bundle bit indices
    localparam int REG_WRITE  = 0;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 2;
    localparam int MEM_TO_REG = 3;
    localparam int ALU_SRC    = 4;
    localparam int REG_DST    = 5;
    localparam int BRANCH     = 6;
    localparam int ALU_OP_LSB = 7;
    localparam int ALU_OP_MSB = 9;

    // Instruction field positions
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    function automatic logic [31:0] sign_ext16(input logic signed [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: an ID instruction reading the destination of a
// load currently in EX must wait one cycle. Purely combinational.
module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       haz
);

    // $0 is hardwired to zero, so a load targeting it can never be consumed.
    assign haz = id_valid & ex_valid & ex_mem_read & (ex_rt != 5'd0)
               & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: drives register file read pointers, captures operands
// and decoded fields, inserts load-use bubbles and squashes on branch flush.
module id_ex_stage #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    output logic [4:0]        R1point,
    output logic [4:0]        R2point,
    input  logic [31:0]       R1,
    input  logic [31:0]       R2,
    output logic              stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [31:0]       ex_pc4,
    output logic [CNT_W-1:0]  bubble_count
);

    import pipe_pkg::*;

    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shamt;
    logic signed [15:0] imm;
    logic               haz;
    logic               unused_opcode;

    assign rs            = id_instr[RS_MSB:RS_LSB];
    assign rt            = id_instr[RT_MSB:RT_LSB];
    assign rd            = id_instr[RD_MSB:RD_LSB];
    assign shamt         = id_instr[SHAMT_MSB:SHAMT_LSB];
    assign imm           = id_instr[IMM_MSB:IMM_LSB];
    assign unused_opcode = ^id_instr[31:26];

    assign R1point = rs;
    assign R2point = rt;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs       (rs),
        .id_rt       (rt),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[MEM_READ]),
        .ex_rt       (ex_rt),
        .haz         (haz)
    );

    // A flush kills the ID instruction anyway, so holding IF/ID would be wasted.
    assign stall = haz & ~flush & rst_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_ctrl      <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_shamt     <= '0;
            ex_pc4       <= '0;
            bubble_count <= '0;
        end else begin
            ex_rs_data <= R1;
            ex_rt_data <= R2;
            ex_imm     <= sign_ext16(imm);
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_rd      <= rd;
            ex_shamt   <= shamt;
            ex_pc4     <= id_pc4;
            if (flush) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
            end else if (haz) begin
                ex_valid     <= 1'b0;
                ex_ctrl      <= '0;
                bubble_count <= sat_inc(bubble_count);
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_valid ? id_ctrl : '0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a behavioural pipeline model checked on
// every negedge, plus literal expectations for the documented scenarios.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam logic [9:0] CTRL_LW   = 10'((1 << REG_WRITE) | (1 << MEM_READ) | (1 << MEM_TO_REG) | (1 << ALU_SRC));
    localparam logic [9:0] CTRL_ADD  = 10'((1 << REG_WRITE) | (1 << REG_DST) | (2 << ALU_OP_LSB));
    localparam logic [9:0] CTRL_ADDI = 10'((1 << REG_WRITE) | (1 << ALU_SRC));

    localparam logic [31:0] I_ADD_8_9_10 = 32'h012A4020;
    localparam logic [31:0] I_LW_2_1     = 32'h8C220000;
    localparam logic [31:0] I_ADD_3_2_4  = 32'h00441820;
    localparam logic [31:0] I_LW_0_1     = 32'h8C200000;
    localparam logic [31:0] I_ADD_3_0_0  = 32'h00001820;
    localparam logic [31:0] I_ADDI_NEG4  = 32'h2001FFFC;
    localparam logic [31:0] I_ADDI_7FFF  = 32'h20017FFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [9:0]  id_ctrl;
    logic        flush;
    logic [4:0]  R1point, R2point;
    logic [31:0] R1, R2;
    logic        stall;
    logic        ex_valid;
    logic [9:0]  ex_ctrl;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [15:0] bubble_count;

    // Narrow-counter instance: reaching all-ones on 16 bits would need 65535
    // hazards, so saturation is exercised on a 2-bit counter sharing the inputs.
    logic [1:0]  sat_count;
    logic        sat_stall, sat_ex_valid;
    logic [4:0]  unused_r1p, unused_r2p, unused_rs, unused_rt, unused_rd, unused_sh;
    logic [9:0]  unused_ctrl;
    logic [31:0] unused_rsd, unused_rtd, unused_imm, unused_pc4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register file stand-in: fixed contents plus one negedge-written override.
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        wr_has = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    function automatic logic [31:0] rf_base(input logic [4:0] a);
        if (a == 5'd0)  return 32'd0;
        if (a == 5'd9)  return 32'd3;
        if (a == 5'd10) return 32'd5;
        return 32'h100 + 32'(a);
    endfunction

    always @(negedge clk) if (wb_en) begin
        wr_has  <= 1'b1;
        wr_addr <= wb_addr;
        wr_data <= wb_data;
    end

    assign R1 = (wr_has && wr_addr == R1point && R1point != 0) ? wr_data : rf_base(R1point);
    assign R2 = (wr_has && wr_addr == R2point && R2point != 0) ? wr_data : rf_base(R2point);

    id_ex_stage u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc4(id_pc4), .id_ctrl(id_ctrl), .flush(flush),
        .R1point(R1point), .R2point(R2point), .R1(R1), .R2(R2), .stall(stall),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_pc4(ex_pc4),
        .bubble_count(bubble_count)
    );

    id_ex_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc4(id_pc4), .id_ctrl(id_ctrl), .flush(flush),
        .R1point(unused_r1p), .R2point(unused_r2p), .R1(R1), .R2(R2), .stall(sat_stall),
        .ex_valid(sat_ex_valid), .ex_ctrl(unused_ctrl), .ex_rs_data(unused_rsd),
        .ex_rt_data(unused_rtd), .ex_imm(unused_imm), .ex_rs(unused_rs), .ex_rt(unused_rt),
        .ex_rd(unused_rd), .ex_shamt(unused_sh), .ex_pc4(unused_pc4),
        .bubble_count(sat_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what EX must hold, derived from the stage rules.
    logic        m_valid = 1'b0;
    logic [9:0]  m_ctrl = '0;
    logic [31:0] m_rs_data = '0, m_rt_data = '0, m_imm = '0, m_pc4 = '0;
    logic [4:0]  m_rs = '0, m_rt = '0, m_rd = '0, m_shamt = '0;
    int          n_bubbles = 0;

    function automatic logic model_haz();
        logic [4:0] s, t;
        s = id_instr[25:21];
        t = id_instr[20:16];
        return id_valid && m_valid && m_ctrl[MEM_READ] && m_rt != 0 && (m_rt == s || m_rt == t);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_ctrl = '0; n_bubbles = 0;
        end else if (flush) begin
            m_valid = 1'b0; m_ctrl = '0;
        end else if (model_haz()) begin
            m_valid = 1'b0; m_ctrl = '0; n_bubbles++;
        end else begin
            m_valid   = id_valid;
            m_ctrl    = id_valid ? id_ctrl : '0;
            m_rs_data = R1;
            m_rt_data = R2;
            m_imm     = 32'(int'($signed(id_instr[15:0])));
            m_rs      = id_instr[25:21];
            m_rt      = id_instr[20:16];
            m_rd      = id_instr[15:11];
            m_shamt   = id_instr[10:6];
            m_pc4     = id_pc4;
        end
    end

    always @(negedge clk) begin
        check("R1point", 32'(R1point), 32'(id_instr[25:21]));
        check("R2point", 32'(R2point), 32'(id_instr[20:16]));
        check("stall", 32'(stall), 32'(rst_n && !flush && model_haz()));
        check("ex_valid", 32'(ex_valid), 32'(m_valid));
        check("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        check("bubble_count", 32'(bubble_count), (n_bubbles < 65535) ? 32'(n_bubbles) : 32'hFFFF);
        check("sat_count", 32'(sat_count), (n_bubbles < 3) ? 32'(n_bubbles) : 32'd3);
        check("sat_ex_valid", 32'(sat_ex_valid), 32'(m_valid));
        if (m_valid) begin
            check("ex_rs_data", ex_rs_data, m_rs_data);
            check("ex_rt_data", ex_rt_data, m_rt_data);
            check("ex_imm", ex_imm, m_imm);
            check("ex_rs", 32'(ex_rs), 32'(m_rs));
            check("ex_rt", 32'(ex_rt), 32'(m_rt));
            check("ex_rd", 32'(ex_rd), 32'(m_rd));
            check("ex_shamt", 32'(ex_shamt), 32'(m_shamt));
            check("ex_pc4", ex_pc4, m_pc4);
        end
    end

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [9:0] c, input logic fl);
        id_valid = v;
        id_instr = ins;
        id_pc4   = pc;
        id_ctrl  = c;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [31:0] pc);
        set_in(1'b1, I_LW_2_1, pc, CTRL_LW, 1'b0);
        tick();
        set_in(1'b1, I_ADD_3_2_4, pc + 4, CTRL_ADD, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, I_ADD_8_9_10, 32'h4, CTRL_ADD, 1'b0);
        tick();
        tick();
        check("rst ex_valid", 32'(ex_valid), 32'd0);
        check("rst ex_ctrl", 32'(ex_ctrl), 32'd0);
        check("rst ex_rs_data", ex_rs_data, 32'd0);
        check("rst ex_imm", ex_imm, 32'd0);
        check("rst ex_pc4", ex_pc4, 32'd0);
        check("rst ex_rd", 32'(ex_rd), 32'd0);
        check("rst bubble_count", 32'(bubble_count), 32'd0);
        check("rst stall", 32'(stall), 32'd0);

        // Normal flow
        rst_n = 1'b1;
        tick();
        check("add ex_rs", 32'(ex_rs), 32'd9);
        check("add ex_rt", 32'(ex_rt), 32'd10);
        check("add ex_rd", 32'(ex_rd), 32'd8);
        check("add ex_rs_data", ex_rs_data, 32'd3);
        check("add ex_rt_data", ex_rt_data, 32'd5);
        check("add ex_pc4", ex_pc4, 32'd4);
        check("add ex_valid", 32'(ex_valid), 32'd1);
        check("add ex_ctrl", 32'(ex_ctrl), 32'(CTRL_ADD));

        // Load-use: one stall cycle, one bubble, then the consumer
        set_in(1'b1, I_LW_2_1, 32'h8, CTRL_LW, 1'b0);
        tick();
        set_in(1'b1, I_ADD_3_2_4, 32'hC, CTRL_ADD, 1'b0);
        #1 check("lu stall", 32'(stall), 32'd1);
        tick();
        check("lu bubble valid", 32'(ex_valid), 32'd0);
        check("lu bubble ctrl", 32'(ex_ctrl), 32'd0);
        check("lu count", 32'(bubble_count), 32'd1);
        check("lu stall cleared", 32'(stall), 32'd0);
        tick();
        check("lu add valid", 32'(ex_valid), 32'd1);
        check("lu add rd", 32'(ex_rd), 32'd3);
        check("lu add rs_data", ex_rs_data, 32'h102);

        // Load into $0 never stalls
        set_in(1'b1, I_LW_0_1, 32'h10, CTRL_LW, 1'b0);
        tick();
        set_in(1'b1, I_ADD_3_0_0, 32'h14, CTRL_ADD, 1'b0);
        #1 check("r0 stall", 32'(stall), 32'd0);
        tick();
        check("r0 add valid", 32'(ex_valid), 32'd1);

        // Flush beats hazard
        set_in(1'b1, I_LW_2_1, 32'h18, CTRL_LW, 1'b0);
        tick();
        set_in(1'b1, I_ADD_3_2_4, 32'h1C, CTRL_ADD, 1'b1);
        #1 check("flush stall", 32'(stall), 32'd0);
        tick();
        check("flush valid", 32'(ex_valid), 32'd0);
        check("flush count", 32'(bubble_count), 32'd1);

        // Invalid ID slot behind a load
        set_in(1'b1, I_LW_2_1, 32'h20, CTRL_LW, 1'b0);
        tick();
        set_in(1'b0, I_ADD_3_2_4, 32'h24, CTRL_ADD, 1'b0);
        #1 check("inv stall", 32'(stall), 32'd0);
        tick();
        check("inv valid", 32'(ex_valid), 32'd0);
        check("inv ctrl", 32'(ex_ctrl), 32'd0);

        // Sign extension
        set_in(1'b1, I_ADDI_NEG4, 32'h28, CTRL_ADDI, 1'b0);
        tick();
        check("imm neg", ex_imm, 32'hFFFFFFFC);
        set_in(1'b1, I_ADDI_7FFF, 32'h2C, CTRL_ADDI, 1'b0);
        tick();
        check("imm pos", ex_imm, 32'h00007FFF);

        // Writeback on the negedge inside the capture cycle
        set_in(1'b1, I_ADD_8_9_10, 32'h30, CTRL_ADD, 1'b0);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
        tick();
        wb_en = 1'b0;
        check("wb ex_rs_data", ex_rs_data, 32'h55);

        // Saturation on the narrow instance
        load_use(32'h40);
        load_use(32'h50);
        check("sat at max", 32'(sat_count), 32'd3);
        load_use(32'h60);
        check("sat held", 32'(sat_count), 32'd3);
        check("wide count", 32'(bubble_count), 32'd4);

        // Reset masks stall even with a live hazard
        set_in(1'b1, I_LW_2_1, 32'h70, CTRL_LW, 1'b0);
        tick();
        set_in(1'b1, I_ADD_3_2_4, 32'h74, CTRL_ADD, 1'b0);
        rst_n = 1'b0;
        #1 check("rst masks stall", 32'(stall), 32'd0);
        tick();
        check("rst2 count", 32'(bubble_count), 32'd0);
        check("rst2 valid", 32'(ex_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
